// File: rtl/mem_arbiter_pkg.sv
`timescale 1ns/1ps
// mem_arbiter_pkg
// Shared types and encodings for the fetch/data memory arbiter.
//   mem_type_bus : access size bus (byte / half / word), shared with the core.
//   arb_state_e  : arbiter FSM states (IDLE / REQ / RSP).
//   owner_e      : which requester owns the in-flight transaction.
package mem_arbiter_pkg;

    localparam int MEM_TYPE_W = 2;

    typedef logic [MEM_TYPE_W-1:0] mem_type_bus;

    localparam mem_type_bus MEM_BYTE = 2'b00;
    localparam mem_type_bus MEM_HALF = 2'b01;
    localparam mem_type_bus MEM_WORD = 2'b10;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_REQ  = 2'b01,
        ARB_RSP  = 2'b10
    } arb_state_e;

    typedef enum logic {
        OWN_IF   = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam int STARVE_CNT_W = 4;
    localparam logic [STARVE_CNT_W-1:0] STARVE_CNT_MAX = '1;

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
`timescale 1ns/1ps
// arb_prio
// Fixed data-over-fetch priority with an anti-starvation counter.
// A pending fetch that loses STARVE_LIMIT arbitrations in a row to data is
// forced to win the next one.
// Ports:
//   clk, rstn      : clock, asynchronous active-low reset
//   i_req, d_req   : fetch / data requests
//   idle           : arbiter is free to accept a new transaction this cycle
//   win_i, win_d   : one-hot winner (both 0 when not idle or nothing pending)
module arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_req,
    input  logic d_req,
    input  logic idle,
    output logic win_i,
    output logic win_d
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = 4'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        win_i        = 1'b0;
        win_d        = 1'b0;
        starve_cnt_d = starve_cnt_q;

        if (idle) begin
            win_i = i_req && (!d_req || (starve_cnt_q >= LIMIT));
            win_d = d_req && !win_i;

            // In an idle cycle the only way fetch neither wins nor is absent
            // is losing to data, so that is the single increment case.
            if (!i_req || win_i) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != STARVE_CNT_MAX) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter
// Shares one single-port memory between the core's instruction-fetch and
// data (load/store) requesters. One transaction in flight at a time.
// Ports:
//   clk, rstn                      : clock, asynchronous active-low reset
//   i_req/i_addr                   : fetch request (held until i_gnt)
//   i_gnt/i_rvalid/i_rdata         : fetch accept pulse, response pulse, data
//   d_req/d_we/d_addr/d_wdata/
//   d_type/d_sign                  : data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata         : data accept pulse, load data / store ack
//   m_req/m_we/m_addr/m_wdata/
//   m_type/m_sign                  : registered request towards memory
//   m_gnt/m_rvalid/m_rdata         : memory accept, response, read data
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rstn,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  mem_type_bus       d_type,
    input  logic              d_sign,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output mem_type_bus       m_type,
    output logic              m_sign,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_e            state_q, state_d;
    owner_e                owner_q, owner_d;

    logic                  m_req_q,   m_req_d;
    logic                  m_we_q,    m_we_d;
    logic [ADDR_W-1:0]     m_addr_q,  m_addr_d;
    logic [DATA_W-1:0]     m_wdata_q, m_wdata_d;
    mem_type_bus           m_type_q,  m_type_d;
    logic                  m_sign_q,  m_sign_d;

    logic                  idle;
    logic                  win_i;
    logic                  win_d;
    logic                  rsp_take;

    // Grants are combinational, so qualify with rstn: a request held high
    // while reset is asserted must not see a gnt pulse.
    assign idle = (state_q == ARB_IDLE) && rstn;

    arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb_prio (
        .clk   (clk),
        .rstn  (rstn),
        .i_req (i_req),
        .d_req (d_req),
        .idle  (idle),
        .win_i (win_i),
        .win_d (win_d)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_type_d  = m_type_q;
        m_sign_d  = m_sign_q;
        rsp_take  = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (win_i) begin
                    state_d   = ARB_REQ;
                    owner_d   = OWN_IF;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = i_addr;
                    m_wdata_d = '0;
                    m_type_d  = MEM_WORD;
                    m_sign_d  = 1'b0;
                end else if (win_d) begin
                    state_d   = ARB_REQ;
                    owner_d   = OWN_DATA;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    m_type_d  = d_type;
                    m_sign_d  = d_sign;
                end
            end

            ARB_REQ: begin
                // m_rvalid before m_gnt is a protocol error and is dropped.
                if (m_gnt) begin
                    m_req_d = 1'b0;
                    if (m_rvalid) begin
                        rsp_take = 1'b1;
                        state_d  = ARB_IDLE;
                    end else begin
                        state_d  = ARB_RSP;
                    end
                end
            end

            ARB_RSP: begin
                if (m_rvalid) begin
                    rsp_take = 1'b1;
                    state_d  = ARB_IDLE;
                end
            end

            default: begin
                state_d = ARB_IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWN_IF;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_type_q  <= MEM_BYTE;
            m_sign_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_type_q  <= m_type_d;
            m_sign_q  <= m_sign_d;
        end
    end

    assign i_gnt    = win_i;
    assign d_gnt    = win_d;
    assign i_rvalid = rsp_take && (owner_q == OWN_IF);
    assign d_rvalid = rsp_take && (owner_q == OWN_DATA);
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_type   = m_type_q;
    assign m_sign   = m_sign_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mem_arbiter: a directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a transaction-level
// reference model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rstn;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req, d_we, d_sign;
    logic [31:0] d_addr, d_wdata;
    mem_type_bus d_type;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req, m_we, m_sign;
    logic [31:0] m_addr, m_wdata;
    mem_type_bus m_type;
    logic        m_gnt, m_rvalid;
    logic [31:0] m_rdata;

    int n_vec = 0;
    int n_err = 0;

    mem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_type   (d_type),
        .d_sign   (d_sign),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_type   (m_type),
        .m_sign   (m_sign),
        .m_gnt    (m_gnt),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_handshakes(input string tag, input logic eig, input logic edg,
                                    input logic emr, input logic eir, input logic edr);
        check_bit({tag, " i_gnt"},    i_gnt,    eig);
        check_bit({tag, " d_gnt"},    d_gnt,    edg);
        check_bit({tag, " m_req"},    m_req,    emr);
        check_bit({tag, " i_rvalid"}, i_rvalid, eir);
        check_bit({tag, " d_rvalid"}, d_rvalid, edr);
    endtask

    task automatic clear_inputs();
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_type = MEM_BYTE; d_sign = 1'b0;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    endtask

    // Leaves the bench at posedge+1 with reset released and the DUT idle.
    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------- table
    typedef struct {
        logic        ir, dr, dwe;
        logic [31:0] ia, da, dwd;
        mem_type_bus dt;
        logic        mg, mr;
        logic [31:0] rd;
        logic        eig, edg, emr, eir, edr;
        logic [31:0] ema;
    } vec_t;

    function automatic vec_t mk(input logic ir, input logic dr, input logic dwe,
                                input logic [31:0] ia, input logic [31:0] da,
                                input logic [31:0] dwd, input mem_type_bus dt,
                                input logic mg, input logic mr, input logic [31:0] rd,
                                input logic eig, input logic edg, input logic emr,
                                input logic eir, input logic edr, input logic [31:0] ema);
        vec_t v;
        v.ir = ir; v.dr = dr; v.dwe = dwe; v.ia = ia; v.da = da; v.dwd = dwd; v.dt = dt;
        v.mg = mg; v.mr = mr; v.rd = rd;
        v.eig = eig; v.edg = edg; v.emr = emr; v.eir = eir; v.edr = edr; v.ema = ema;
        return v;
    endfunction

    vec_t tbl[11];

    // ---------------------------------------------------------------- model
    // Transaction-level view: at most one transaction owned by a requester,
    // either still waiting for the memory to accept it or already accepted.
    bit          t_active, t_accepted, t_is_data;
    bit          t_we, t_sign;
    logic [31:0] t_addr, t_wdata;
    mem_type_bus t_type;
    int          fetch_losses;

    initial begin
        rstn = 1'b0;
        clear_inputs();
        do_reset();

        // Reset state.
        @(negedge clk);
        check_handshakes("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_bit("reset m_we", m_we, 1'b0);
        check_word("reset m_addr", m_addr, 32'h0);
        check_word("reset m_wdata", m_wdata, 32'h0);
        check_word("reset m_type", 32'(m_type), 32'h0);
        check_bit("reset m_sign", m_sign, 1'b0);
        next_cycle();

        // ------------------------------------------------ directed table
        //              ir dr we ia       da       dwd      type      mg mr rd            ig dg mr ir dr ma
        tbl[0]  = mk(1, 1, 0, 32'h400, 32'h800, 32'h0,   MEM_WORD, 0, 0, 32'h0,        0, 1, 0, 0, 0, 32'h0);
        tbl[1]  = mk(1, 0, 0, 32'h400, 32'h0,   32'h0,   MEM_WORD, 1, 1, 32'hA5A5A5A5, 0, 0, 1, 0, 1, 32'h800);
        tbl[2]  = mk(1, 0, 0, 32'h400, 32'h0,   32'h0,   MEM_WORD, 0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0);
        tbl[3]  = mk(0, 0, 0, 32'h0,   32'h0,   32'h0,   MEM_WORD, 1, 1, 32'h00000013, 0, 0, 1, 1, 0, 32'h400);
        tbl[4]  = mk(0, 0, 0, 32'h0,   32'h0,   32'h0,   MEM_WORD, 0, 1, 32'h11111111, 0, 0, 0, 0, 0, 32'h0);
        tbl[5]  = mk(0, 1, 1, 32'h0,   32'h900, 32'h55,  MEM_HALF, 0, 1, 32'h22222222, 0, 1, 0, 0, 0, 32'h0);
        tbl[6]  = mk(0, 0, 0, 32'h0,   32'h0,   32'h0,   MEM_WORD, 0, 1, 32'h33333333, 0, 0, 1, 0, 0, 32'h900);
        tbl[7]  = mk(0, 0, 0, 32'h0,   32'h0,   32'h0,   MEM_WORD, 1, 0, 32'h0,        0, 0, 1, 0, 0, 32'h900);
        tbl[8]  = mk(0, 0, 0, 32'h0,   32'h0,   32'h0,   MEM_WORD, 1, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0);
        tbl[9]  = mk(0, 0, 0, 32'h0,   32'h0,   32'h0,   MEM_WORD, 0, 1, 32'hCAFEF00D, 0, 0, 0, 0, 1, 32'h0);
        tbl[10] = mk(1, 1, 0, 32'h500, 32'hA00, 32'h0,   MEM_WORD, 0, 0, 32'h0,        0, 1, 0, 0, 0, 32'h0);

        for (int k = 0; k < 11; k++) begin
            i_req = tbl[k].ir; i_addr = tbl[k].ia;
            d_req = tbl[k].dr; d_we = tbl[k].dwe; d_addr = tbl[k].da;
            d_wdata = tbl[k].dwd; d_type = tbl[k].dt; d_sign = 1'b0;
            m_gnt = tbl[k].mg; m_rvalid = tbl[k].mr; m_rdata = tbl[k].rd;
            @(negedge clk);
            check_handshakes($sformatf("tbl%0d", k), tbl[k].eig, tbl[k].edg,
                             tbl[k].emr, tbl[k].eir, tbl[k].edr);
            if (tbl[k].emr) check_word($sformatf("tbl%0d m_addr", k), m_addr, tbl[k].ema);
            if (tbl[k].eir) check_word($sformatf("tbl%0d i_rdata", k), i_rdata, tbl[k].rd);
            if (tbl[k].edr) check_word($sformatf("tbl%0d d_rdata", k), d_rdata, tbl[k].rd);
            next_cycle();
        end

        // ------------------------------------------------ single fetch
        do_reset();
        i_req = 1'b1; i_addr = 32'h100;
        @(negedge clk);
        check_handshakes("fetch c0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        i_req = 1'b0; m_gnt = 1'b1;
        @(negedge clk);
        check_handshakes("fetch c1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_word("fetch c1 m_addr", m_addr, 32'h100);
        check_bit("fetch c1 m_we", m_we, 1'b0);
        check_word("fetch c1 m_type", 32'(m_type), 32'(MEM_WORD));
        next_cycle();
        m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h00000013;
        @(negedge clk);
        check_handshakes("fetch c2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_word("fetch c2 i_rdata", i_rdata, 32'h00000013);
        next_cycle();
        m_rvalid = 1'b0;
        @(negedge clk);
        check_handshakes("fetch c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();

        // ------------------------------------------------ store, stalled memory
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_type = MEM_BYTE;
        @(negedge clk);
        check_handshakes("store c0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle();
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_type = MEM_WORD;
        for (int c = 1; c <= 4; c++) begin
            m_gnt = (c == 4);
            @(negedge clk);
            check_handshakes($sformatf("store c%0d", c), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            check_bit($sformatf("store c%0d m_we", c), m_we, 1'b1);
            check_word($sformatf("store c%0d m_addr", c), m_addr, 32'h2004);
            check_word($sformatf("store c%0d m_wdata", c), m_wdata, 32'hDEADBEEF);
            check_word($sformatf("store c%0d m_type", c), 32'(m_type), 32'(MEM_BYTE));
            next_cycle();
        end
        m_gnt = 1'b0; m_rvalid = 1'b1;
        @(negedge clk);
        check_handshakes("store ack", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        m_rvalid = 1'b0;

        // ------------------------------------------------ starvation
        do_reset();
        i_req = 1'b1; i_addr = 32'h1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_type = MEM_WORD;
        m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h77;
        for (int c = 0; c < 20; c++) begin
            bit fetch_turn;
            fetch_turn = ((c / 2) % (LIMIT + 1)) == LIMIT;
            @(negedge clk);
            if (c % 2 == 0) begin
                check_handshakes($sformatf("starve c%0d", c), fetch_turn, !fetch_turn,
                                 1'b0, 1'b0, 1'b0);
            end else begin
                check_handshakes($sformatf("starve c%0d", c), 1'b0, 1'b0, 1'b1,
                                 fetch_turn, !fetch_turn);
                check_word($sformatf("starve c%0d m_addr", c), m_addr,
                           fetch_turn ? 32'h1000 : 32'h2000);
            end
            next_cycle();
        end

        // ------------------------------------------------ reset mid-response
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_type = MEM_WORD;
        @(negedge clk);
        check_handshakes("rst c0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle();
        d_req = 1'b0; m_gnt = 1'b1;
        @(negedge clk);
        check_handshakes("rst c1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        next_cycle();
        m_gnt = 1'b0;
        i_req = 1'b1; i_addr = 32'h4000; d_req = 1'b1;
        #1 rstn = 1'b0;
        m_rvalid = 1'b1;
        #1;
        check_handshakes("rst asserted", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_word("rst asserted m_addr", m_addr, 32'h0);
        check_bit("rst asserted m_we", m_we, 1'b0);
        next_cycle();
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0;
        rstn = 1'b1;
        m_rvalid = 1'b1; m_rdata = 32'hBADBAD00;
        @(negedge clk);
        check_handshakes("rst stale rsp", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        m_rvalid = 1'b0;
        i_req = 1'b1; i_addr = 32'h0;
        @(negedge clk);
        check_handshakes("rst fetch c0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        i_req = 1'b0; m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h55;
        @(negedge clk);
        check_handshakes("rst fetch c1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_word("rst fetch c1 m_addr", m_addr, 32'h0);
        check_word("rst fetch c1 i_rdata", i_rdata, 32'h55);
        next_cycle();

        // ------------------------------------------------ randomized vs model
        do_reset();
        t_active = 0; t_accepted = 0; t_is_data = 0; fetch_losses = 0;
        t_we = 0; t_sign = 0; t_addr = '0; t_wdata = '0; t_type = MEM_BYTE;
        for (int c = 0; c < 3000; c++) begin
            bit e_ig, e_dg, e_ir, e_dr, e_mreq;
            if (!i_req && ($urandom_range(0, 2) == 0)) begin
                i_req  = 1'b1;
                i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_req && ($urandom_range(0, 2) == 0)) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_type  = mem_type_bus'($urandom_range(0, 2));
                d_sign  = 1'($urandom_range(0, 1));
            end
            m_gnt    = 1'($urandom_range(0, 1));
            m_rvalid = 1'($urandom_range(0, 1));
            m_rdata  = $urandom;

            // Expected outputs from the transaction view.
            e_ig = !t_active && i_req && (!d_req || fetch_losses >= LIMIT);
            e_dg = !t_active && d_req && !e_ig;
            e_mreq = t_active && !t_accepted;
            e_ir = t_active && !t_is_data && m_rvalid && (t_accepted || m_gnt);
            e_dr = t_active &&  t_is_data && m_rvalid && (t_accepted || m_gnt);

            @(negedge clk);
            check_handshakes($sformatf("rnd%0d", c), e_ig, e_dg, e_mreq, e_ir, e_dr);
            if (e_mreq) begin
                check_word($sformatf("rnd%0d m_addr", c), m_addr, t_addr);
                check_bit($sformatf("rnd%0d m_we", c), m_we, t_we);
                check_word($sformatf("rnd%0d m_wdata", c), m_wdata, t_wdata);
                check_word($sformatf("rnd%0d m_type", c), 32'(m_type), 32'(t_type));
                check_bit($sformatf("rnd%0d m_sign", c), m_sign, t_sign);
            end
            if (e_ir) check_word($sformatf("rnd%0d i_rdata", c), i_rdata, m_rdata);
            if (e_dr) check_word($sformatf("rnd%0d d_rdata", c), d_rdata, m_rdata);

            // Advance the model by one clock.
            if (!t_active) begin
                if (!i_req || e_ig) fetch_losses = 0;
                else if (fetch_losses < 15) fetch_losses++;
                if (e_ig) begin
                    t_active = 1; t_accepted = 0; t_is_data = 0;
                    t_we = 0; t_addr = i_addr; t_wdata = '0; t_type = MEM_WORD; t_sign = 0;
                end else if (e_dg) begin
                    t_active = 1; t_accepted = 0; t_is_data = 1;
                    t_we = d_we; t_addr = d_addr; t_wdata = d_wdata; t_type = d_type; t_sign = d_sign;
                end
            end else if (e_ir || e_dr) begin
                t_active = 0;
            end else if (!t_accepted && m_gnt) begin
                t_accepted = 1;
            end

            next_cycle();
            if (e_ig) i_req = 1'b0;
            if (e_dg) d_req = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified single-port memory between the core's instruction-fetch requester and its data (load/store) requester.
- Sits between the riscv core's fetch/MEM-stage interfaces and the memory.
- One outstanding transaction at a time; fixed data-over-fetch priority, with an anti-starvation counter that guarantees fetch progress.
- The core stalls on the per-requester gnt/rvalid handshakes.

Parameters:
- ADDR_W, 32, address width (matches RegBus).
- DATA_W, 32, data width (matches RegBus).
- STARVE_LIMIT, 4, consecutive arbitration losses of a pending fetch before fetch is forced to win; legal 1..15.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous assert, active-low.
- i_req  in  1  fetch request; held until i_gnt.
- i_addr  in  ADDR_W  fetch address.
- i_gnt  out  1  fetch request accepted (one-cycle pulse).
- i_rvalid  out  1  fetch data valid (one-cycle pulse).
- i_rdata  out  DATA_W  fetch data.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_type  in  mem_type_bus  byte/half/word.
- d_sign  in  1  load sign-extend.
- d_gnt  out  1  data request accepted (pulse).
- d_rvalid  out  1  load data / store ack (pulse).
- d_rdata  out  DATA_W  load data.
- m_req  out  1  memory request.
- m_we  out  1  memory write.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_type  out  mem_type_bus  access size.
- m_sign  out  1  sign-extend.
- m_gnt  in  1  memory accepted request.
- m_rvalid  in  1  memory response; issued for reads and writes.
- m_rdata  in  DATA_W  memory read data.

Behaviour:
- FSM states: IDLE, REQ, RSP. Internal registers: owner (0 = fetch, 1 = data) and starve_cnt (4 bits).
- Reset (async, rstn = 0):
  - state = IDLE, owner = 0, starve_cnt = 0.
  - m_req, m_we, m_addr, m_wdata, m_type, m_sign = 0.
  - i_gnt, d_gnt, i_rvalid, d_rvalid = 0.
  - Any in-flight transaction is dropped; no rvalid is ever produced for it.
- IDLE arbitration (combinational in the same cycle):
  - winner = fetch if (i_req && (!d_req || starve_cnt >= STARVE_LIMIT)); otherwise data if d_req.
  - The winner's gnt is asserted this cycle.
  - Winner fields are latched into m_* registers (fetch forces m_we = 0, m_wdata = 0, m_type = word, m_sign = 0).
  - owner is latched; next state = REQ.
  - No request: stay in IDLE, gnts = 0.
- starve_cnt:
  - Increments (saturating at 15) in each IDLE cycle where i_req && d_req and data wins.
  - Clears when fetch wins, or in any IDLE cycle with i_req = 0.
  - Holds otherwise.
- REQ:
  - m_req = 1, fields stable.
  - On m_gnt: m_req is cleared next cycle; next state = RSP.
  - If m_gnt && m_rvalid occur in the same cycle: response is forwarded this cycle, next state = IDLE.
- RSP:
  - m_req = 0, waiting for m_rvalid.
  - On m_rvalid: next state = IDLE.
- Response forwarding is combinational, no added latency:
  - i_rvalid = m_rvalid && owner == 0 && state ∈ {REQ-with-m_gnt, RSP}. d_rvalid is the same with owner == 1.
  - i_rdata = d_rdata = m_rdata unconditionally; valid only under the respective rvalid.
- m_rvalid arriving in IDLE, or in REQ without m_gnt, is ignored (protocol error, no output).
- Minimum latency: req at cycle 0 (gnt) → m_req at cycle 1 → rvalid at cycle 1 if the memory answers in the grant cycle. Back-to-back throughput is one transaction per 2 cycles minimum.
- Requests arriving while not in IDLE wait; their gnt stays 0.
- Simultaneous i_req and d_req with starve_cnt < STARVE_LIMIT: data wins.

Decomposition:
- Add to defines.v:
  - ARB_IDLE / ARB_REQ / ARB_RSP state encodings (2-bit).
  - OWN_IF / OWN_DATA.
  - Reuse the existing mem_type_bus and word-type constant.
- One natural sub-module, arb_prio:
  - Combinational winner select plus the starve_cnt register.
  - Inputs i_req, d_req, idle.
  - Outputs win_i, win_d.
- FSM and the m_* registers stay in mem_arbiter.

Test Plan:
- Reset mid-RSP (data load in flight, rstn pulsed low) → all outputs 0 immediately; after release no d_rvalid; fresh i_req at addr 0x0 is served normally.
- Single fetch, i_addr = 0x100, memory grants in cycle 1 and returns 0x00000013 in cycle 2 → i_gnt at c0, m_req at c1 with m_addr = 0x100 and m_we = 0, i_rvalid with i_rdata = 0x13 at c2, d_rvalid never set.
- Store: d_we = 1, d_addr = 0x2004, d_wdata = 0xDEADBEEF, d_type = byte → m_* fields match exactly, held stable while m_gnt is held low for 3 cycles, d_rvalid on ack.
- Simultaneous i_req and d_req → data granted first, fetch granted on the next IDLE; zero-latency memory (m_gnt and m_rvalid together) → each transaction completes in 2 cycles.
- Starvation: d_req held continuously, i_req held, STARVE_LIMIT = 4 → data wins 4 arbitrations, fetch wins the 5th, starve_cnt returns to 0.
- Spurious m_rvalid while IDLE → no i_rvalid or d_rvalid; state stays IDLE.
